// File: rtl/prog_loader_pkg.sv
// ============================================================================
// prog_loader_pkg : shared state, error codes and defaults for prog_loader
// Rev 1.0
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_ARMED      = 3'd2,
    ST_RESET_CORE = 3'd3,
    ST_RUN        = 3'd4,
    ST_DONE       = 3'd5,
    ST_ERR        = 3'd6
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_OVERFLOW = 2'b01,
    ERR_TIMEOUT  = 2'b10
  } err_t;

  localparam int DEFAULT_RST_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/prog_loader_run_timer.sv
// ============================================================================
// run_timer : RUN-cycle counter with clear/enable and MAX_CYCLES timeout flag
// Rev 1.0
// ============================================================================
`default_nettype none

module run_timer #(
  parameter int CNT_WIDTH  = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_timeout
);

  localparam logic [CNT_WIDTH-1:0] c_max  = CNT_WIDTH'(MAX_CYCLES);
  localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(MAX_CYCLES - 1);

  logic [CNT_WIDTH-1:0] r_count;

  // Saturating at MAX_CYCLES guarantees the count can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != c_max)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted in the enabled cycle whose increment lands on MAX_CYCLES.
  assign o_timeout = i_en && (r_count == c_last);
  assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// prog_loader : streams a program into instruction memory, then resets,
//               starts and times the core until done or timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int PC_WIDTH    = 12,
  parameter int INSTR_WIDTH = 9,
  parameter int RST_CYCLES  = DEFAULT_RST_CYCLES,
  parameter int CNT_WIDTH   = 16,
  parameter int MAX_CYCLES  = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [INSTR_WIDTH-1:0] ld_data,
  input  logic                   ld_last,
  input  logic                   start,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   core_reset,
  output logic                   core_req,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   finished,
  output logic [1:0]             error,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [PC_WIDTH:0]      words_loaded
);

  localparam int c_rcw = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_rcw-1:0]  c_rst_last = c_rcw'(RST_CYCLES - 1);
  localparam logic [PC_WIDTH:0] c_ptr_last = (PC_WIDTH+1)'((1 << PC_WIDTH) - 1);

  loader_state_t         r_state;
  loader_state_t         w_next_state;
  logic [PC_WIDTH:0]     r_wr_ptr;
  logic [PC_WIDTH:0]     r_words_loaded;
  err_t                  r_err;
  logic [c_rcw-1:0]      r_rst_cnt;
  logic [CNT_WIDTH-1:0]  w_count;
  logic                  w_accept;
  logic                  w_run_start;
  logic                  w_rst_done;
  logic                  w_ptr_full;
  logic                  w_timeout;
  logic                  w_in_run;

  assign ld_ready   = (r_state != ST_RESET_CORE) && (r_state != ST_RUN);
  assign w_accept   = ld_valid && ld_ready;
  assign w_rst_done = (r_rst_cnt == c_rst_last);
  assign w_ptr_full = (r_wr_ptr == c_ptr_last);
  assign w_in_run   = (r_state == ST_RUN);

  assign imem_we      = w_accept;
  assign imem_wdata   = ld_data;
  assign imem_addr    = (r_state == ST_LOAD) ? r_wr_ptr[PC_WIDTH-1:0] : '0;
  assign error        = r_err;
  assign words_loaded = r_words_loaded;
  assign cycle_count  = w_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_run_start  = 1'b0;
    busy         = 1'b0;
    finished     = 1'b0;
    core_reset   = 1'b1;
    core_req     = 1'b0;
    case (r_state)
      ST_IDLE, ST_ERR: begin
        if (w_accept) w_next_state = ld_last ? ST_ARMED : ST_LOAD;
      end
      ST_ARMED, ST_DONE: begin
        finished = (r_state == ST_DONE);
        // A word arriving alongside start begins a new program instead of a run.
        if (w_accept) begin
          w_next_state = ld_last ? ST_ARMED : ST_LOAD;
        end else if (start) begin
          w_next_state = ST_RESET_CORE;
          w_run_start  = 1'b1;
        end
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (w_accept) begin
          if (ld_last)         w_next_state = ST_ARMED;
          else if (w_ptr_full) w_next_state = ST_ERR;
        end
      end
      ST_RESET_CORE: begin
        busy = 1'b1;
        if (w_rst_done) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = 1'b0;
        core_req   = (w_count == '0);
        if (core_done)      w_next_state = ST_DONE;
        else if (w_timeout) w_next_state = ST_ERR;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr       <= '0;
      r_words_loaded <= '0;
      r_err          <= ERR_NONE;
      r_rst_cnt      <= '0;
    end else begin
      if (w_accept) begin
        if (r_state == ST_LOAD) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          if (ld_last)         r_words_loaded <= r_wr_ptr + 1'b1;
          else if (w_ptr_full) r_err          <= ERR_OVERFLOW;
        end else begin
          r_wr_ptr <= (PC_WIDTH+1)'(1);
          r_err    <= ERR_NONE;
          if (ld_last) r_words_loaded <= (PC_WIDTH+1)'(1);
        end
      end
      if (w_in_run && w_timeout && !core_done) r_err <= ERR_TIMEOUT;
      r_rst_cnt <= ((r_state == ST_RESET_CORE) && !w_rst_done) ? r_rst_cnt + 1'b1 : '0;
    end
  end

  run_timer #(
    .CNT_WIDTH  (CNT_WIDTH),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_clr     (w_run_start),
    .i_en      (w_in_run),
    .o_count   (w_count),
    .o_timeout (w_timeout)
  );

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// tb_prog_loader : directed table-driven and sequence checks for prog_loader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int PW   = 3;
  localparam int IW   = 9;
  localparam int CW   = 16;
  localparam int MAXC = 100;
  localparam int RSTC = 2;

  logic          clk;
  logic          reset;
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_data;
  logic          ld_last;
  logic          start;
  logic          imem_we;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          core_reset;
  logic          core_req;
  logic          core_done;
  logic          busy;
  logic          finished;
  logic [1:0]    error;
  logic [CW-1:0] cycle_count;
  logic [PW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  prog_loader #(
    .PC_WIDTH    (PW),
    .INSTR_WIDTH (IW),
    .RST_CYCLES  (RSTC),
    .CNT_WIDTH   (CW),
    .MAX_CYCLES  (MAXC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .start        (start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .core_req     (core_req),
    .core_done    (core_done),
    .busy         (busy),
    .finished     (finished),
    .error        (error),
    .cycle_count  (cycle_count),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic [IW-1:0] d;
    logic          last;
    logic          st;
    logic          e_we;
    logic [PW-1:0] e_addr;
    logic          e_busy;
    logic [PW:0]   e_wl;
  } vec_t;

  vec_t vecs[12];

  // Drive one word for a single cycle and check the combinational write port.
  task automatic load_word(input logic [IW-1:0] d, input logic l, input logic [PW-1:0] a);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = d; ld_last = l;
    #2;
    chk($sformatf("ld_we[%0h]", d), 32'(imem_we), 32'd1);
    chk($sformatf("ld_addr[%0h]", d), 32'(imem_addr), 32'(a));
    chk($sformatf("ld_wdata[%0h]", d), 32'(imem_wdata), 32'(d));
    @(posedge clk);
    #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Issue start from ARMED/DONE, follow the reset hold and RUN phase, and
  // raise core_done on RUN cycle done_at (0 = never, expect timeout).
  task automatic do_run(input int done_at, input logic noise);
    int k;
    @(negedge clk);
    start = 1'b1;
    #2;
    chk("pre_run_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; ld_valid = noise; ld_data = 9'h133;
    repeat (RSTC) begin
      #2;
      chk("rc_core_reset", 32'(core_reset), 32'd1);
      chk("rc_busy", 32'(busy), 32'd1);
      chk("rc_ready", 32'(ld_ready), 32'd0);
      chk("rc_we", 32'(imem_we), 32'd0);
      chk("rc_req", 32'(core_req), 32'd0);
      chk("rc_count", 32'(cycle_count), 32'd0);
      @(negedge clk);
    end
    for (k = 1; k <= MAXC; k++) begin
      core_done = (k == done_at);
      #2;
      chk($sformatf("run%0d_core_reset", k), 32'(core_reset), 32'd0);
      chk($sformatf("run%0d_req", k), 32'(core_req), 32'(k == 1));
      chk($sformatf("run%0d_count", k), 32'(cycle_count), 32'(k - 1));
      chk($sformatf("run%0d_we", k), 32'(imem_we), 32'd0);
      if (k == done_at) break;
      @(negedge clk);
    end
    @(negedge clk);
    core_done = 1'b0; ld_valid = 1'b0;
    #2;
  endtask

  initial begin
    reset = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    start = 1'b0; core_done = 1'b0;

    //            v   d       last st  we  addr busy wl
    vecs[0]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 9'h1A0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 4'd0};
    vecs[4]  = '{1'b1, 9'h0F5, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd0};
    vecs[5]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 4'd0};
    vecs[6]  = '{1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 4'd0};
    vecs[7]  = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd3};
    vecs[8]  = '{1'b1, 9'h055, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'd3};
    vecs[9]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 4'd3};
    vecs[10] = '{1'b1, 9'h0AA, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 4'd3};
    vecs[11] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd2};

    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_req", 32'(core_req), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finished", 32'(finished), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Program load, idle gaps, ignored starts, and load-beats-start in ARMED.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ld_valid = vecs[i].v; ld_data = vecs[i].d; ld_last = vecs[i].last; start = vecs[i].st;
      #2;
      chk($sformatf("v%0d_we", i), 32'(imem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].v) chk($sformatf("v%0d_wdata", i), 32'(imem_wdata), 32'(vecs[i].d));
      chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'd1);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_core_reset", i), 32'(core_reset), 32'd1);
      chk($sformatf("v%0d_finished", i), 32'(finished), 32'd0);
      chk($sformatf("v%0d_wl", i), 32'(words_loaded), 32'(vecs[i].e_wl));
      chk($sformatf("v%0d_count", i), 32'(cycle_count), 32'd0);
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;

    // Normal run, done on RUN cycle 50.
    do_run(50, 1'b0);
    chk("run50_finished", 32'(finished), 32'd1);
    chk("run50_count", 32'(cycle_count), 32'd50);
    chk("run50_core_reset", 32'(core_reset), 32'd1);
    chk("run50_busy", 32'(busy), 32'd0);
    chk("run50_error", 32'(error), 32'd0);
    @(negedge clk);
    #2;
    chk("run50_frozen", 32'(cycle_count), 32'd50);

    // Rerun from DONE with host traffic that must not be accepted.
    do_run(20, 1'b1);
    chk("rerun_finished", 32'(finished), 32'd1);
    chk("rerun_count", 32'(cycle_count), 32'd20);
    chk("rerun_wl", 32'(words_loaded), 32'd2);

    // Timeout.
    do_run(0, 1'b0);
    chk("to_error", 32'(error), 32'd2);
    chk("to_count", 32'(cycle_count), 32'(MAXC));
    chk("to_core_reset", 32'(core_reset), 32'd1);
    chk("to_ready", 32'(ld_ready), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_finished", 32'(finished), 32'd0);

    // start in ERR is ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("err_start_busy", 32'(busy), 32'd0);
    chk("err_start_error", 32'(error), 32'd2);

    // Overflow: fill all 8 addresses with no ld_last.
    for (int i = 0; i < 8; i++) begin
      load_word(IW'(i * 3 + 1), 1'b0, PW'(i));
      if (i == 0) chk("ovf_err_cleared", 32'(error), 32'd0);
    end
    @(negedge clk);
    #2;
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_ready", 32'(ld_ready), 32'd1);
    load_word(9'h1C3, 1'b1, 3'd0);
    chk("reload_error", 32'(error), 32'd0);
    chk("reload_wl", 32'(words_loaded), 32'd1);
    chk("reload_busy", 32'(busy), 32'd0);

    // done and timeout in the same cycle: done wins.
    do_run(MAXC, 1'b0);
    chk("tie_finished", 32'(finished), 32'd1);
    chk("tie_error", 32'(error), 32'd0);
    chk("tie_count", 32'(cycle_count), 32'(MAXC));

    // Asynchronous reset during RUN cycle 10.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RSTC + 9) @(negedge clk);
    #2;
    chk("ar_pre_core_reset", 32'(core_reset), 32'd0);
    chk("ar_pre_count", 32'(cycle_count), 32'd9);
    reset = 1'b0;
    #1;
    chk("ar_core_reset", 32'(core_reset), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_count", 32'(cycle_count), 32'd0);
    chk("ar_ready", 32'(ld_ready), 32'd1);
    chk("ar_wl", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("ar_idle_start_busy", 32'(busy), 32'd0);
    chk("ar_idle_core_reset", 32'(core_reset), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
